// File: rtl/calc_defs.sv
// Shared definitions for the switch calculator: sequencer states, field widths
// and the opcode bit that marks single-operand operations.
package calc_defs;

   localparam int OPCODE_W  = 3;
   localparam int UNARY_BIT = 2;
   localparam int OPERAND_W = 4;
   localparam int RESULT_W  = 8;

   typedef enum logic [2:0] {
      GET_A    = 3'd0,
      GET_OP   = 3'd1,
      GET_B    = 3'd2,
      ISSUE    = 3'd3,
      WAIT_RES = 3'd4,
      SHOW     = 3'd5
   } seq_state_t;

   function automatic logic is_unary(input logic [OPCODE_W-1:0] opcode);
      return opcode[UNARY_BIT];
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter, and a
// registered single-cycle pulse on each accepted press (never on release).
module btn_debounce #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   logic        sync1_q;
   logic        sync2_q;
   logic        stable_q;
   logic        stable_d;
   logic        stable_prev_q;
   logic        press_q;
   logic [19:0] cnt_q;
   logic [19:0] cnt_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + 20'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         press_q       <= 1'b0;
         cnt_q         <= '0;
      end else begin
         sync1_q       <= btn_i;
         sync2_q       <= sync1_q;
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         // pulse lags the stable-level rise by one cycle
         press_q       <= stable_q & ~stable_prev_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/switch_entry_seq.sv
// Operand/opcode entry sequencer in front of switch_calc: collects A, opcode and B
// from switches on debounced presses, issues one request, and captures the result.
module switch_entry_seq
   import calc_defs::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1000
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic [OPERAND_W-1:0] sw_num,
   input  logic [1:0]           sw_op,
   input  logic                 sw_mode,
   input  logic                 btn_done,
   output logic                 req_valid,
   input  logic                 req_ready,
   output logic [OPERAND_W-1:0] req_a,
   output logic [OPERAND_W-1:0] req_b,
   output logic [OPCODE_W-1:0]  req_opcode,
   input  logic                 res_valid,
   input  logic [RESULT_W-1:0]  res_data,
   output logic [RESULT_W-1:0]  result,
   output logic                 err,
   output logic [2:0]           state
);

   localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 16'd1);

   logic                 press;
   seq_state_t           state_q;
   logic                 req_valid_q;
   logic [OPERAND_W-1:0] a_q;
   logic [OPERAND_W-1:0] b_q;
   logic [OPCODE_W-1:0]  opcode_q;
   logic [RESULT_W-1:0]  result_q;
   logic                 err_q;
   logic [TIMER_W-1:0]   timer_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i  (CLK),
      .rst_i  (reset),
      .btn_i  (btn_done),
      .press_o(press)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= GET_A;
         req_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         opcode_q    <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         timer_q     <= '0;
      end else begin
         case (state_q)
            GET_A, SHOW: begin
               if (press) begin
                  a_q     <= sw_num;
                  err_q   <= 1'b0;
                  state_q <= GET_OP;
               end
            end
            GET_OP: begin
               if (press) begin
                  opcode_q <= {sw_mode, sw_op};
                  if (is_unary({sw_mode, sw_op})) begin
                     b_q         <= '0;
                     req_valid_q <= 1'b1;
                     state_q     <= ISSUE;
                  end else begin
                     state_q <= GET_B;
                  end
               end
            end
            GET_B: begin
               if (press) begin
                  b_q         <= sw_num;
                  req_valid_q <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               if (req_ready) begin
                  req_valid_q <= 1'b0;
                  timer_q     <= '0;
                  state_q     <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               // a result arriving in the final timeout cycle still wins
               if (res_valid) begin
                  result_q <= res_data;
                  state_q  <= SHOW;
               end else if (timer_q == TIMER_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= GET_A;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: begin
               req_valid_q <= 1'b0;
               state_q     <= GET_A;
            end
         endcase
      end
   end

   assign req_valid  = req_valid_q;
   assign req_a      = a_q;
   assign req_b      = b_q;
   assign req_opcode = opcode_q;
   assign result     = result_q;
   assign err        = err_q;
   assign state      = state_q;

endmodule
